// File: rtl/spi_master_multi.sv
// spi_master_multi
// Parametrised SPI master: DATA_W-bit words, all four CPOL/CPHA modes,
// MSB- or LSB-first shifting and NUM_CS active-low chip selects with an
// optional hold of the chip select across consecutive words.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        transfer request, accepted only when idle
//   din          transmit word (latched on accept)
//   clk_divider  SCLK half-period minus one, in clk cycles (latched)
//   cpol, cpha   SPI mode (latched; cpol also sets the idle SCLK level)
//   lsb_first    bit order (latched)
//   cs_sel       chip select index; out-of-range selects nothing (latched)
//   cs_keep      keep chip select asserted after this word (latched)
//   miso         serial input (asynchronous, synchronised internally)
//   sclk, mosi   serial clock and data out
//   cs_n         active-low chip selects
//   busy, done   transfer in progress / one-cycle completion pulse
//   dout         received word, valid from done until the next accept
module spi_master_multi #(
    parameter  int DATA_W = 8,
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 8,
    localparam int CS_W   = $clog2(NUM_CS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [DIV_W-1:0]  clk_divider,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cs_keep,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LEAD,
        S_TRAIL,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_divCnt;
    logic [BIT_W-1:0]   r_bitCnt;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_lsb;
    logic               r_keep;
    logic [DATA_W-1:0]  r_tx;
    logic [DATA_W-1:0]  r_rx;
    logic               r_misoMeta;
    logic               r_misoSync;
    logic               r_sclk;
    logic               r_mosi;
    logic [NUM_CS-1:0]  r_csN;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_dout;

    logic               w_phaseEnd;
    logic               w_lastBit;
    logic               w_txNextBit;
    logic [DATA_W-1:0]  w_txShift;
    logic [DATA_W-1:0]  w_rxNext;
    logic [NUM_CS-1:0]  w_csDec;

    assign w_phaseEnd  = (r_divCnt == r_div);
    assign w_lastBit   = (r_bitCnt == BIT_W'(DATA_W - 1));
    assign w_txShift   = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    assign w_txNextBit = r_lsb ? r_tx[1] : r_tx[DATA_W-2];
    assign w_rxNext    = r_lsb ? {r_misoSync, r_rx[DATA_W-1:1]}
                               : {r_rx[DATA_W-2:0], r_misoSync};

    // One-hot active-low decode; an index with no matching output leaves
    // every chip select released, which also drops any held select.
    always_comb begin
        w_csDec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i)) begin
                w_csDec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_stateNext = S_SETUP;
            S_SETUP: if (w_phaseEnd) w_stateNext = S_LEAD;
            S_LEAD:  if (w_phaseEnd) w_stateNext = S_TRAIL;
            S_TRAIL: if (w_phaseEnd) w_stateNext = w_lastBit ? S_HOLD : S_LEAD;
            S_HOLD:  if (w_phaseEnd) w_stateNext = S_IDLE;
            default:                 w_stateNext = S_IDLE;
        endcase
    end

    // Datapath. Every SCLK edge is produced at the end of a phase, so the
    // leading edge appears after LEAD and the trailing edge after TRAIL.
    // The chip select is driven in the accept cycle so that it is already
    // low in the first SETUP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= '0;
            r_divCnt   <= '0;
            r_bitCnt   <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_keep     <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_misoMeta <= 1'b0;
            r_misoSync <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_csN      <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_misoMeta <= miso;
            r_misoSync <= r_misoMeta;
            r_done     <= 1'b0;

            if (r_state == S_IDLE || w_phaseEnd) begin
                r_divCnt <= '0;
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_sclk <= cpol;
                    r_mosi <= 1'b0;
                    if (start) begin
                        r_div    <= clk_divider;
                        r_cpol   <= cpol;
                        r_cpha   <= cpha;
                        r_lsb    <= lsb_first;
                        r_keep   <= cs_keep;
                        r_tx     <= din;
                        r_rx     <= '0;
                        r_bitCnt <= '0;
                        r_mosi   <= lsb_first ? din[0] : din[DATA_W-1];
                        r_csN    <= w_csDec;
                        r_busy   <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (w_phaseEnd) begin
                        r_sclk <= ~r_cpol;
                        if (!r_cpha) begin
                            r_rx <= w_rxNext;
                        end else if (r_bitCnt != '0) begin
                            // Bit 0 was already presented during SETUP.
                            r_tx   <= w_txShift;
                            r_mosi <= w_txNextBit;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_phaseEnd) begin
                        r_sclk   <= r_cpol;
                        r_bitCnt <= r_bitCnt + BIT_W'(1);
                        if (!r_cpha) begin
                            r_tx   <= w_txShift;
                            r_mosi <= w_txNextBit;
                        end else begin
                            r_rx <= w_rxNext;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_phaseEnd) begin
                        r_dout <= r_rx;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_mosi <= 1'b0;
                        if (!r_keep) begin
                            r_csN <= '1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign cs_n = r_csN;
    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi
// Self-checking bench for spi_master_multi (DATA_W=8, NUM_CS=4, DIV_W=8).
// A table of transfer vectors is applied in a loop; hand-written sequences
// cover chip-select hold, back-to-back words, ignored mid-transfer changes
// and reset during a transfer. Received words are checked by a scoreboard
// queue filled when each word is driven and drained on every done pulse.
module tb_spi_master_multi;

    localparam int DW   = 8;
    localparam int NCS  = 4;
    localparam int DIVW = 8;

    typedef struct {
        int          misoMode;   // 0: loopback of mosi, 1: tied high, 2: slave schedule
        logic        cpol;
        logic        cpha;
        logic        lsb;
        int          div;
        int          cs;
        logic        keep;
        logic [7:0]  din;
        logic [7:0]  slave;
        logic [7:0]  expDout;
        logic [3:0]  expCsN;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [DW-1:0]   din;
    logic [DIVW-1:0] clkDivider;
    logic            cpol;
    logic            cpha;
    logic            lsbFirst;
    logic [1:0]      csSel;
    logic            csKeep;
    logic            miso;
    logic            sclk;
    logic            mosi;
    logic [NCS-1:0]  csN;
    logic            busy;
    logic            done;
    logic [DW-1:0]   dout;

    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              misoMode = 2;
    int              slaveT0 = -100;
    vec_t            slaveVec;
    logic            schedBit = 1'b0;
    logic [7:0]      expQ[$];
    vec_t            vecs[7];

    spi_master_multi #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DIVW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .din        (din),
        .clk_divider(clkDivider),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsb_first  (lsbFirst),
        .cs_sel     (csSel),
        .cs_keep    (csKeep),
        .miso       (miso),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (csN),
        .busy       (busy),
        .done       (done),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    assign miso = (misoMode == 0) ? mosi : (misoMode == 1) ? 1'b1 : schedBit;

    // The master reads miso through two flops, so a bit sampled in the edge
    // cycle s must be on the wire two cycles earlier. The slave drives each
    // bit for exactly that one cycle and 0 otherwise, so sampling on the
    // wrong edge reads zeros instead of the slave word.
    function automatic logic slaveBit(input int c);
        int s;
        for (int k = 0; k < DW; k++) begin
            s = slaveT0 + (slaveVec.div + 1) * (2 * k + 2 + int'(slaveVec.cpha));
            if (c == s - 2) begin
                return slaveVec.lsb ? slaveVec.slave[k] : slaveVec.slave[DW-1-k];
            end
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        schedBit = slaveBit(cyc);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse consumes the oldest expected word.
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_unexpected_done: got dout %0h, expected no done", dout);
            end else begin
                checkOutput("sb_dout", dout, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        misoMode   = v.misoMode;
        cpol       = v.cpol;
        cpha       = v.cpha;
        lsbFirst   = v.lsb;
        clkDivider = DIVW'(v.div);
        csSel      = 2'(v.cs);
        csKeep     = v.keep;
        din        = v.din;
    endtask

    // Called just after a posedge with the DUT idle. Runs one word and
    // checks busy length, chip selects, the mosi bits seen on the sampling
    // edges and the state in the done cycle. With disturb set, start is
    // pulsed and every input is changed while the word is in flight.
    task automatic runTransfer(input vec_t v, input bit disturb);
        int         busyCnt = 0;
        int         csBad = 0;
        int         capCnt = 0;
        logic [7:0] capWord = '0;
        logic       prevSclk;
        bit         doneSeen = 0;
        applyStimulus(v);
        slaveVec = v;
        slaveT0  = cyc;
        start    = 1'b1;
        expQ.push_back(v.expDout);
        @(posedge clk);
        #1;
        start    = 1'b0;
        prevSclk = v.cpol;
        for (int n = 0; n < 5000 && !doneSeen; n++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                busyCnt++;
                if (csN !== v.expCsN) csBad++;
                if (sclk !== prevSclk) begin
                    if ((sclk !== v.cpol) != v.cpha) begin
                        capWord = v.lsb ? {mosi, capWord[7:1]} : {capWord[6:0], mosi};
                        capCnt++;
                    end
                    prevSclk = sclk;
                end
            end
            if (done === 1'b1) begin
                doneSeen = 1;
                checkOutput("busy_in_done_cycle", busy, 1'b0);
                checkOutput("cs_after_done", csN, v.keep ? v.expCsN : 4'hF);
                checkOutput("mosi_idle", mosi, 1'b0);
            end
            if (disturb && busyCnt == 10) begin
                start      = 1'b1;
                din        = ~v.din;
                csSel      = 2'(v.cs + 1);
                cpol       = ~v.cpol;
                cpha       = ~v.cpha;
                lsbFirst   = ~v.lsb;
                clkDivider = 8'd7;
                csKeep     = ~v.keep;
            end
            if (disturb && busyCnt == 12) start = 1'b0;
        end
        checkOutput("done_seen", doneSeen, 1'b1);
        checkOutput("busy_len", busyCnt, (2 * DW + 2) * (v.div + 1));
        checkOutput("cs_during", csBad, 0);
        checkOutput("mosi_bits", capWord, v.din);
        checkOutput("sample_edges", capCnt, DW);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t       v;
        vec_t       vk;
        int         accepts;
        int         words;
        int         lastDone;
        bit         prevBusy;
        bit         busyCheckPending;
        logic [7:0] b2b[3];

        reset = 1'b1; start = 1'b0; din = '0; clkDivider = '0; cpol = 1'b0;
        cpha = 1'b0; lsbFirst = 1'b0; csSel = '0; csKeep = 1'b0;

        vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 8'hA5, 8'h00, 8'hA5, 4'b1101};
        vecs[1] = '{2, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 8'h96, 8'h3C, 8'h3C, 4'b1110};
        vecs[2] = '{2, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0, 8'h96, 8'h3C, 8'h3C, 4'b1101};
        vecs[3] = '{2, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 8'h96, 8'h3C, 8'h3C, 4'b1011};
        vecs[4] = '{2, 1'b1, 1'b1, 1'b0, 0, 3, 1'b0, 8'h96, 8'h3C, 8'h3C, 4'b0111};
        vecs[5] = '{1, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0, 8'h01, 8'h00, 8'hFF, 4'b1011};
        vecs[6] = '{2, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 8'h6B, 8'hC9, 8'hC9, 4'b1110};
        slaveVec = vecs[0];

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_sclk", sclk, 1'b0);
        checkOutput("rst_mosi", mosi, 1'b0);
        checkOutput("rst_cs_n", csN, 4'hF);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_dout", dout, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            cpol = vecs[i].cpol;
            repeat (2) @(posedge clk);
            @(negedge clk);
            checkOutput("idle_sclk", sclk, vecs[i].cpol);
            @(posedge clk);
            #1;
            runTransfer(vecs[i], 1'b0);
        end

        // Chip select 2 held across two words, then released.
        vk = '{0, 1'b0, 1'b0, 1'b0, 3, 2, 1'b1, 8'h5A, 8'h00, 8'h5A, 4'b1011};
        @(posedge clk); #1;
        runTransfer(vk, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("cs_held_gap", csN, 4'b1011);
        @(posedge clk); #1;
        vk.keep = 1'b0; vk.din = 8'hC4; vk.expDout = 8'hC4;
        runTransfer(vk, 1'b0);
        // Held select 2 must be dropped as soon as select 0 is accepted.
        @(posedge clk); #1;
        vk.keep = 1'b1; vk.din = 8'h3E; vk.expDout = 8'h3E;
        runTransfer(vk, 1'b0);
        @(posedge clk); #1;
        vk.cs = 0; vk.keep = 1'b0; vk.din = 8'h81; vk.expDout = 8'h81; vk.expCsN = 4'b1110;
        runTransfer(vk, 1'b0);

        // Mid-transfer start pulse and input changes are ignored.
        @(posedge clk); #1;
        v = '{0, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 8'hB2, 8'h00, 8'hB2, 4'b1101};
        runTransfer(v, 1'b1);

        // start held high: each following word is accepted in the done cycle.
        @(posedge clk); #1;
        b2b = '{8'h11, 8'hE7, 8'h4C};
        v = '{0, 1'b0, 1'b0, 1'b0, 2, 3, 1'b0, b2b[0], 8'h00, b2b[0], 4'b0111};
        applyStimulus(v);
        start = 1'b1;
        expQ.push_back(b2b[0]);
        accepts = 0; words = 0; lastDone = -1; prevBusy = 0; busyCheckPending = 0;
        for (int n = 0; n < 1000 && words < 3; n++) begin
            @(negedge clk);
            if (busyCheckPending) begin
                checkOutput("b2b_accept_in_done", busy, 1'b1);
                busyCheckPending = 0;
            end
            if (busy === 1'b1 && !prevBusy) begin
                accepts++;
                if (accepts < 3) begin
                    din = b2b[accepts];
                    expQ.push_back(b2b[accepts]);
                end else begin
                    start = 1'b0;
                end
            end
            prevBusy = (busy === 1'b1);
            if (done === 1'b1) begin
                words++;
                checkOutput("b2b_busy_low", busy, 1'b0);
                if (lastDone >= 0) checkOutput("b2b_gap", cyc - lastDone, (2 * DW + 2) * 3 + 1);
                lastDone = cyc;
                if (words < 3) busyCheckPending = 1;
            end
        end
        checkOutput("b2b_words", words, 3);
        start = 1'b0;

        // Reset during the trailing half of bit 4, then a clean transfer.
        @(posedge clk); #1;
        v = '{0, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 8'hC3, 8'h00, 8'hC3, 4'b1101};
        applyStimulus(v);
        start = 1'b1;
        expQ.push_back(v.expDout);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (41) @(posedge clk);
        #1;
        checkOutput("pre_reset_sclk", sclk, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("mid_rst_sclk", sclk, 1'b0);
        checkOutput("mid_rst_cs_n", csN, 4'hF);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_dout", dout, 8'h00);
        @(posedge clk); #1;
        v.din = 8'h69; v.expDout = 8'h69;
        runTransfer(v, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master for the peripheral I/O subsystem. It generalises the byte-wide mode-0 master with configurable word width, all four SPI modes (CPOL/CPHA), selectable bit order, and NUM_CS active-low chip selects with optional CS hold across words. The CPU-side I/O register block drives it with a start/busy/done handshake.

Parameters:
DATA_W, 8, bits per transfer word (>=2)
NUM_CS, 4, number of chip-select outputs (>=2)
DIV_W, 8, width of clk_divider
CS_W, $clog2(NUM_CS), width of cs_sel (derived; do not override)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  request a transfer; accepted only in IDLE
din  in  DATA_W  transmit word, latched on accept
clk_divider  in  DIV_W  SCLK half-period = clk_divider+1 clk cycles, latched on accept
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accept
lsb_first  in  1  1: shift LSB first; latched on accept
cs_sel  in  CS_W  chip select index, latched on accept
cs_keep  in  1  keep CS asserted after this word; latched on accept
miso  in  1  serial input, asynchronous
sclk  out  1  serial clock
mosi  out  1  serial output
cs_n  out  NUM_CS  active-low chip selects
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
dout  out  DATA_W  received word, valid from done until next accept

Behaviour:
- Reset (also mid-transfer): state=IDLE, sclk=0, mosi=0, cs_n=all 1, busy=0, done=0, dout=0, bit counter/divider=0. All outputs registered.
- miso passes through a 2-flop synchroniser; "sampled" means the synchroniser output in the edge cycle.
- States: IDLE -> SETUP -> LEAD -> TRAIL -> (LEAD, or HOLD after bit DATA_W-1) -> IDLE. SETUP, LEAD, TRAIL and HOLD each last clk_divider+1 cycles.
- IDLE: sclk <= cpol every cycle. busy=0. On start, latch all config, load tx/rx shift registers, and enter SETUP. busy=1 from the next cycle.
- SETUP: cs_n[cs_sel] driven low. If a different CS is still held, it is released in the same cycle. mosi = first bit (din[DATA_W-1], or din[0] if lsb_first).
- LEAD end: sclk <= !cpol. CPHA=0: sample into rx. CPHA=1: mosi <= next bit, except on bit 0 where the first bit is already presented.
- TRAIL end: sclk <= cpol. CPHA=0: mosi <= next bit. CPHA=1: sample into rx. Increment bit counter.
- rx shifts MSB-first (in at bit 0, shift left) or LSB-first (in at bit DATA_W-1, shift right), matching lsb_first.
- HOLD: sclk=cpol, CS still asserted. At HOLD end: go to IDLE, dout <= rx, done=1 for one cycle, busy=0 in that same cycle. Release CS unless cs_keep.
- busy duration: exactly (2*DATA_W+2)*(clk_divider+1) cycles.
- start held high: the next transfer is accepted in the first IDLE cycle, i.e. the done cycle, giving back-to-back words.
- start while busy: ignored. Input changes while busy: no effect.
- cs_sel >= NUM_CS: no CS asserted, transfer otherwise normal. Any held CS is released.
- clk_divider=0: sclk = clk/2.
- mosi returns to 0 in IDLE.

Test Plan:
- Mode 0, MSB-first, DATA_W=8, div=3, cs_sel=1, din=0xA5, miso loopback of mosi -> mosi bits 1,0,1,0,0,1,0,1; cs_n=4'b1101 during transfer; busy high 72 cycles; done pulse; dout=0xA5; cs_n=4'hF after.
- All four modes, div=0, slave model drives 0x3C -> dout=0x3C in each mode. sclk idle = cpol. Sampling edge matches cpha.
- lsb_first=1, din=0x01, miso tied 1 -> first mosi bit=1 then 0s; dout=0xFF.
- cs_keep=1 on cs 2 for two words, then cs_keep=0 -> cs_n[2] low continuously across both words and through second HOLD, then 1. Switch to cs 0 while cs 2 held -> cs 2 released at new SETUP.
- start held high for 3 words -> each accepted in the done cycle; start pulses during busy ignored; config changes mid-transfer have no effect.
- Reset asserted mid-bit 4 -> next cycle: sclk=0, cs_n=all 1, busy=0, dout=0. A new transfer afterwards completes correctly.
